// File: rtl/inst_mem_dumper.sv
// Memory read-back streamer: reads a run of 32-bit words from a synchronous-read port
// and sends each word as four bytes, LSB first, over a valid/ready byte stream.
//
// state  | meaning
// IDLE   | waiting for dump_start; a zero-length request only pulses done
// ADDR   | mem_addr presented, memory samples it this edge
// WAIT   | mem_rdata valid, word captured and first byte launched
// SEND   | bytes held until accepted; last accept moves to next word or finishes
module inst_mem_dumper #(
  parameter int MEM_WIDTH = 2
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 dump_start,
  input  logic                 dump_abort,
  input  logic [MEM_WIDTH-1:0] start_addr,
  input  logic [MEM_WIDTH:0]   dump_count,
  output logic [MEM_WIDTH-1:0] mem_addr,
  input  logic [31:0]          mem_rdata,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2,
    S_SEND = 2'd3
  } state_t;

  localparam logic [MEM_WIDTH:0] DEPTH = {1'b1, {MEM_WIDTH{1'b0}}};

  state_t               r_state;
  logic [MEM_WIDTH-1:0] r_mem_addr;
  logic [MEM_WIDTH:0]   r_words_left;
  logic [31:0]          r_buf;
  logic [1:0]           r_byte_idx;
  logic [7:0]           r_tx_data;
  logic                 r_tx_valid;
  logic                 r_busy;
  logic                 r_done;

  logic [MEM_WIDTH:0]   w_words_init;
  logic                 w_accept;
  logic [4:0]           w_next_bit;

  // At most one full memory image per request
  assign w_words_init = (dump_count > DEPTH) ? DEPTH : dump_count;
  assign w_accept     = r_tx_valid & tx_ready;
  assign w_next_bit   = {r_byte_idx + 2'd1, 3'b000};

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_mem_addr   <= '0;
      r_words_left <= '0;
      r_buf        <= '0;
      r_byte_idx   <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (dump_start) begin
          if (dump_count == '0) begin
            r_done <= 1'b1;
          end else begin
            r_mem_addr   <= start_addr;
            r_words_left <= w_words_init;
            r_busy       <= 1'b1;
            r_state      <= S_ADDR;
          end
        end
      end else if (dump_abort) begin
        // Abort wins over any accept presented on the same edge
        r_tx_valid <= 1'b0;
        r_busy     <= 1'b0;
        r_state    <= S_IDLE;
      end else begin
        case (r_state)
          S_ADDR: r_state <= S_WAIT;
          S_WAIT: begin
            r_buf      <= mem_rdata;
            r_tx_data  <= mem_rdata[7:0];
            r_tx_valid <= 1'b1;
            r_byte_idx <= 2'd0;
            r_state    <= S_SEND;
          end
          S_SEND: begin
            if (w_accept) begin
              if (r_byte_idx != 2'd3) begin
                r_tx_data  <= r_buf[w_next_bit +: 8];
                r_byte_idx <= r_byte_idx + 2'd1;
              end else begin
                r_tx_valid   <= 1'b0;
                r_words_left <= r_words_left - (MEM_WIDTH+1)'(1);
                if (r_words_left == (MEM_WIDTH+1)'(1)) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                end else begin
                  r_mem_addr <= r_mem_addr + MEM_WIDTH'(1);
                  r_state    <= S_ADDR;
                end
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign mem_addr = r_mem_addr;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
